// File: rtl/fifo_rr_arbiter_if.sv
// Purpose: bundle of the requester-side and FIFO-side stream signals of the
//          round-robin FIFO write-port arbiter.
// Signals:
//   s_valid/s_ready/s_last [NREQ]  per-requester beat handshake and end-of-burst
//   s_data [NREQ*SIZE]             requester i data at [i*SIZE +: SIZE]
//   m_valid/m_ready                beat handshake toward the FIFO write port
//   m_data [SIZE], m_id [IDW]      beat payload and index of its source
// Modports:
//   master  arbiter side (drives s_ready and the m_* beat toward the FIFO)
//   slave   environment side (producers and FIFO)
// Handshake: a beat transfers on a rising clk edge where valid and ready are
//   both high; a requester never retracts valid before its beat is accepted.
interface fifo_rr_arbiter_if #(
   parameter int NREQ = 4,
   parameter int SIZE = 32,
   parameter int IDW  = $clog2(NREQ)
);
   logic [NREQ-1:0]      s_valid;
   logic [NREQ-1:0]      s_ready;
   logic [NREQ-1:0]      s_last;
   logic [NREQ*SIZE-1:0] s_data;
   logic                 m_valid;
   logic                 m_ready;
   logic [SIZE-1:0]      m_data;
   logic [IDW-1:0]       m_id;

   modport master (
      input  s_valid, s_last, s_data, m_ready,
      output s_ready, m_valid, m_data, m_id
   );

   modport slave (
      output s_valid, s_last, s_data, m_ready,
      input  s_ready, m_valid, m_data, m_id
   );
endinterface

// File: rtl/fifo_rr_arbiter.sv
// Purpose: round-robin arbiter sharing one sync FIFO write port among NREQ
//          valid/ready stream requesters. A grant is held for a burst that
//          ends on s_last or after MAX_BURST beats, then re-arbitrated with
//          the just-released requester at lowest priority.
// Ports:
//   clk        clock, all state on the rising edge
//   reset_n    asynchronous, active-low reset
//   bus        fifo_rr_arbiter_if.master (requester streams in, FIFO beat out)
//   state_dbg  current FSM state (0 = IDLE, 1 = BUSY)
module fifo_rr_arbiter #(
   parameter int NREQ      = 4,
   parameter int SIZE      = 32,
   parameter int MAX_BURST = 8,
   parameter int IDW       = $clog2(NREQ),
   parameter int CW        = $clog2(MAX_BURST + 1)
) (
   input  logic              clk,
   input  logic              reset_n,
   fifo_rr_arbiter_if.master bus,
   output logic              state_dbg
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t          state;
   logic [IDW-1:0]  grant;
   logic [IDW-1:0]  last_grant;
   logic [CW-1:0]   cnt;

   logic [IDW-1:0]  next_grant;
   logic [IDW-1:0]  cand;
   logic            sel_valid;
   logic            sel_last;
   logic            hs;
   logic            release_burst;

   // Rotating priority search starting just after last_grant. Walking the
   // offsets from farthest to nearest lets the nearest valid requester win.
   always_comb begin
      next_grant = last_grant;
      cand       = '0;
      for (int k = NREQ; k >= 1; k--) begin
         cand = IDW'((int'(last_grant) + k) % NREQ);
         if (bus.s_valid[cand]) begin
            next_grant = cand;
         end
      end
   end

   // Granted-requester mux. m_data follows the granted slot in every state,
   // so after reset it shows slot 0.
   always_comb begin
      sel_valid   = 1'b0;
      sel_last    = 1'b0;
      bus.m_data  = bus.s_data[SIZE-1:0];
      bus.s_ready = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant == IDW'(i)) begin
            sel_valid  = bus.s_valid[i];
            sel_last   = bus.s_last[i];
            bus.m_data = bus.s_data[i*SIZE +: SIZE];
            if (state == BUSY) begin
               bus.s_ready[i] = bus.m_ready;
            end
         end
      end
   end

   // m_valid depends only on s_valid and registered state, never on m_ready.
   assign bus.m_valid   = (state == BUSY) & sel_valid;
   assign bus.m_id      = grant;
   assign hs            = bus.m_valid & bus.m_ready;
   // s_last and the beat limit coinciding still produce a single release.
   assign release_burst = hs & (sel_last | (cnt == CW'(MAX_BURST - 1)));
   assign state_dbg     = (state == BUSY);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         grant      <= '0;
         last_grant <= IDW'(NREQ - 1);
         cnt        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|bus.s_valid) begin
                  grant <= next_grant;
                  cnt   <= '0;
                  state <= BUSY;
               end
            end
            BUSY: begin
               // A stalled FIFO or an idle granted requester simply holds
               // everything; there is no timeout.
               if (release_burst) begin
                  last_grant <= grant;
                  cnt        <= '0;
                  state      <= IDLE;
               end else if (hs) begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Purpose: self-checking bench for fifo_rr_arbiter. Producers replay
//          per-requester beat lists; a transaction-level round-robin model
//          fills the expected queue; directed steps check reset, rotation,
//          burst splitting, stalls, priority and mid-burst reset, followed
//          by randomized rounds.
module tb_fifo_rr_arbiter;

   localparam int NREQ      = 4;
   localparam int SIZE      = 32;
   localparam int MAX_BURST = 8;
   localparam int IDW       = $clog2(NREQ);
   localparam int W         = IDW + SIZE;
   localparam int DEPTH     = 64;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset_n;
   logic state_dbg;

   always #5 clk = ~clk;

   fifo_rr_arbiter_if #(.NREQ(NREQ), .SIZE(SIZE)) bus ();

   fifo_rr_arbiter #(
      .NREQ     (NREQ),
      .SIZE     (SIZE),
      .MAX_BURST(MAX_BURST)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus),
      .state_dbg(state_dbg)
   );

   // ---------------- producers and scoreboard ----------------
   logic [SIZE-1:0] beat_data [NREQ][DEPTH];
   logic            beat_last [NREQ][DEPTH];
   int              beat_cnt  [NREQ];
   int              beat_head [NREQ];

   logic [W-1:0]    exp_q[$];
   int              acc_cyc[$];
   int              acc_id[$];
   int              model_last;
   int              n_checks;
   int              n_fails;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_prod();
      for (int i = 0; i < NREQ; i++) begin
         beat_cnt[i]  = 0;
         beat_head[i] = 0;
      end
   endtask

   task automatic load_beat(input int r, input logic last);
      beat_data[r][beat_cnt[r]] = $urandom;
      beat_last[r][beat_cnt[r]] = last;
      beat_cnt[r]++;
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < NREQ; i++) begin
         if (beat_head[i] < beat_cnt[i]) begin
            bus.s_valid[i]              = 1'b1;
            bus.s_last[i]               = beat_last[i][beat_head[i]];
            bus.s_data[i*SIZE +: SIZE]  = beat_data[i][beat_head[i]];
         end else begin
            bus.s_valid[i]              = 1'b0;
            bus.s_last[i]               = 1'b0;
            bus.s_data[i*SIZE +: SIZE]  = 32'hDEAD_0000 | i;
         end
      end
   endtask

   // Whole-burst round-robin model: the next owner is the first requester
   // with pending beats after the previous owner; a burst runs until a
   // last-marked beat or MAX_BURST beats.
   task automatic model_expected();
      int  h[NREQ];
      int  r;
      int  n;
      int  idx;
      bit  found;
      bit  more;
      for (int i = 0; i < NREQ; i++) h[i] = beat_head[i];
      more = 1'b1;
      while (more) begin
         found = 1'b0;
         r     = 0;
         for (int k = 1; k <= NREQ; k++) begin
            idx = (model_last + k) % NREQ;
            if (!found && h[idx] < beat_cnt[idx]) begin
               found = 1'b1;
               r     = idx;
            end
         end
         if (!found) begin
            more = 1'b0;
         end else begin
            n = 0;
            do begin
               exp_q.push_back({IDW'(r), beat_data[r][h[r]]});
               n++;
               h[r]++;
            end while (!beat_last[r][h[r]-1] && n < MAX_BURST && h[r] < beat_cnt[r]);
            model_last = r;
         end
      end
   endtask

   function automatic bit all_done();
      bit d;
      d = (exp_q.size() == 0);
      for (int i = 0; i < NREQ; i++) begin
         if (beat_head[i] != beat_cnt[i]) d = 1'b0;
      end
      return d;
   endfunction

   // ready_mode: 0 = FIFO always ready, 1 = random, 2 = stalled in cycles 3..5
   task automatic run(input int budget, input int ready_mode, input bit expect_done);
      logic [NREQ-1:0] pop;
      logic [63:0]     exp_beat;
      bit              done;
      int              c;
      acc_cyc.delete();
      acc_id.delete();
      done = all_done();
      c    = 0;
      while (!done && c < budget) begin
         case (ready_mode)
            0:       bus.m_ready = 1'b1;
            1:       bus.m_ready = ($urandom_range(0, 9) < 7);
            default: bus.m_ready = !(c >= 3 && c <= 5);
         endcase
         drive_inputs();
         #1;
         check("s_ready_onehot", 64'($countones(bus.s_ready) <= 1), 64'd1);
         check("s_ready_when_full", 64'(bus.s_ready & {NREQ{~bus.m_ready}}), 64'd0);
         if (ready_mode == 2 && c >= 3 && c <= 5) begin
            check("stall_m_valid", 64'(bus.m_valid), 64'd1);
            check("stall_s_ready1", 64'(bus.s_ready[1]), 64'd0);
         end
         if (bus.m_valid && bus.m_ready) begin
            acc_cyc.push_back(c);
            acc_id.push_back(int'(bus.m_id));
            check("s_ready_granted", 64'(bus.s_ready), 64'd1 << bus.m_id);
            exp_beat = (exp_q.size() > 0) ? 64'(exp_q.pop_front()) : 64'hFFFF_FFFF_FFFF_FFFF;
            check("beat", 64'({bus.m_id, bus.m_data}), exp_beat);
         end
         pop = bus.s_valid & bus.s_ready;
         @(posedge clk);
         #1;
         for (int i = 0; i < NREQ; i++) begin
            if (pop[i]) beat_head[i]++;
         end
         c++;
         done = all_done();
      end
      if (expect_done) check("run_done", 64'(done), 64'd1);
   endtask

   // ---------------- directed and random steps ----------------
   initial begin
      int exp4[10] = '{1, 2, 6, 7, 8, 9, 10, 11, 13, 14};
      int exp2[5]  = '{0, 1, 2, 3, 0};
      int n;

      n_checks   = 0;
      n_fails    = 0;
      model_last = NREQ - 1;
      clear_prod();

      // Reset held with every requester valid.
      reset_n     = 1'b0;
      bus.m_ready = 1'b1;
      bus.s_valid = '1;
      bus.s_last  = '0;
      for (int i = 0; i < NREQ; i++) bus.s_data[i*SIZE +: SIZE] = 32'hA5A5_0000 + i;
      repeat (3) begin
         @(posedge clk);
         #1;
         check("rst_m_valid", 64'(bus.m_valid), 64'd0);
         check("rst_s_ready", 64'(bus.s_ready), 64'd0);
         check("rst_m_id", 64'(bus.m_id), 64'd0);
         check("rst_m_data", 64'(bus.m_data), 64'hA5A5_0000);
         check("rst_state", 64'(state_dbg), 64'd0);
      end
      drive_inputs();
      reset_n = 1'b1;

      // All four valid, last on every beat: rotation 0,1,2,3,0 at 1 beat / 2 cycles.
      clear_prod();
      load_beat(0, 1'b1);
      load_beat(0, 1'b1);
      load_beat(1, 1'b1);
      load_beat(2, 1'b1);
      load_beat(3, 1'b1);
      model_expected();
      run(100, 0, 1'b1);
      check("t2_count", 64'(acc_cyc.size()), 64'd5);
      for (int k = 0; k < 5 && k < acc_cyc.size(); k++) begin
         check("t2_cycle", 64'(acc_cyc[k]), 64'(1 + 2 * k));
         check("t2_id", 64'(acc_id[k]), 64'(exp2[k]));
      end

      // Lone requester 2, 20 beats: bursts 8,8,4 with one idle cycle between.
      clear_prod();
      for (int b = 0; b < 20; b++) load_beat(2, b == 19);
      model_expected();
      run(100, 0, 1'b1);
      check("t3_count", 64'(acc_cyc.size()), 64'd20);
      for (int b = 0; b < 20 && b < acc_cyc.size(); b++) begin
         check("t3_cycle", 64'(acc_cyc[b]), 64'(1 + b + b / MAX_BURST));
      end

      // Requester 1 with FIFO stalled for 3 cycles mid-burst.
      clear_prod();
      for (int b = 0; b < 10; b++) load_beat(1, b == 9);
      model_expected();
      run(100, 2, 1'b1);
      check("t4_count", 64'(acc_cyc.size()), 64'd10);
      for (int b = 0; b < 10 && b < acc_cyc.size(); b++) begin
         check("t4_cycle", 64'(acc_cyc[b]), 64'(exp4[b]));
      end

      // last_grant = 0, then req 0 and 3 valid: 3 wins first.
      clear_prod();
      load_beat(0, 1'b1);
      model_expected();
      run(100, 0, 1'b1);
      clear_prod();
      load_beat(0, 1'b1);
      load_beat(3, 1'b1);
      model_expected();
      run(100, 0, 1'b1);
      check("t5_count", 64'(acc_id.size()), 64'd2);
      if (acc_id.size() == 2) begin
         check("t5_first", 64'(acc_id[0]), 64'd3);
         check("t5_second", 64'(acc_id[1]), 64'd0);
      end

      // Reset in the middle of a burst on requester 1.
      clear_prod();
      for (int b = 0; b < 10; b++) load_beat(1, b == 9);
      model_expected();
      run(4, 0, 1'b0);
      check("t6_partial", 64'(acc_cyc.size()), 64'd3);
      reset_n = 1'b0;
      #1;
      check("t6_m_valid", 64'(bus.m_valid), 64'd0);
      check("t6_s_ready", 64'(bus.s_ready), 64'd0);
      check("t6_state", 64'(state_dbg), 64'd0);
      check("t6_m_id", 64'(bus.m_id), 64'd0);
      exp_q.delete();
      model_last = NREQ - 1;
      clear_prod();
      drive_inputs();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      load_beat(1, 1'b1);
      load_beat(0, 1'b1);
      model_expected();
      run(100, 0, 1'b1);
      check("t6_count", 64'(acc_id.size()), 64'd2);
      if (acc_id.size() == 2) begin
         check("t6_first", 64'(acc_id[0]), 64'd0);
         check("t6_second", 64'(acc_id[1]), 64'd1);
      end

      // Randomized rounds against the model.
      for (int r = 0; r < 8; r++) begin
         clear_prod();
         for (int i = 0; i < NREQ; i++) begin
            n = $urandom_range(0, 12);
            for (int b = 0; b < n; b++) load_beat(i, (b == n - 1) || ($urandom_range(0, 3) == 0));
         end
         model_expected();
         run(800, 1, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
